// File: rtl/rc4_decrypt_core.sv
// RC4 decryption engine driving external single-port S RAM, ciphertext ROM and plaintext RAM.
// One start runs S init, key schedule and keystream decryption, with optional early abort on non-text bytes.
module rc4_decrypt_core #(
  parameter int KEY_LENGTH      = 3,
  parameter int MSG_LENGTH      = 32,
  parameter bit CHECK_PLAINTEXT = 1'b1,
  parameter int ADDR_W          = 5
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [8*KEY_LENGTH-1:0] key,
  output logic [7:0]              s_address,
  output logic [7:0]              s_data,
  output logic                    s_wren,
  input  logic [7:0]              s_q,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [7:0]              rom_q,
  output logic [ADDR_W-1:0]       dec_address,
  output logic [7:0]              dec_data,
  output logic                    dec_wren,
  output logic                    busy,
  output logic                    done,
  output logic                    key_valid
);

  localparam int KEY_W = 8 * KEY_LENGTH;
  localparam int K_W   = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LENGTH - 1);

  typedef enum logic [4:0] {
    IDLE, INIT,
    K_RD_I, K_WT_I, K_RD_J, K_WT_J, K_WR_I, K_WR_J,
    P_RD_I, P_WT_I, P_RD_J, P_WT_J, P_WR_I, P_WR_J, P_RD_F, P_WT_F, P_OUT,
    FINISH
  } state_t;

  state_t           state_reg;
  logic [7:0]       i_reg, j_reg, si_reg, sj_reg, ct_reg;
  logic [K_W-1:0]   k_reg;
  logic [KEY_W-1:0] key_reg, key_rot;
  logic [7:0]       j_ksa, j_prga, pt_byte;
  logic             pt_legal;

  // The latched key rotates one byte per KSA step, so the top byte is always key[i mod KEY_LENGTH].
  generate
    if (KEY_LENGTH == 1) begin : g_rot_single
      assign key_rot = key_reg;
    end else begin : g_rot_multi
      assign key_rot = {key_reg[KEY_W-9:0], key_reg[KEY_W-1 -: 8]};
    end
  endgenerate

  assign j_ksa    = j_reg + s_q + key_reg[KEY_W-1 -: 8];
  assign j_prga   = j_reg + s_q;
  assign pt_byte  = s_q ^ ct_reg;
  assign pt_legal = ((pt_byte >= 8'h61) && (pt_byte <= 8'h7A)) || (pt_byte == 8'h20);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      i_reg       <= '0;
      j_reg       <= '0;
      k_reg       <= '0;
      si_reg      <= '0;
      sj_reg      <= '0;
      ct_reg      <= '0;
      key_reg     <= '0;
      s_address   <= '0;
      s_data      <= '0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      dec_address <= '0;
      dec_data    <= '0;
      dec_wren    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      key_valid   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          key_reg   <= key;
          done      <= 1'b0;
          key_valid <= 1'b0;
          busy      <= 1'b1;
          i_reg     <= '0;
          j_reg     <= '0;
          k_reg     <= '0;
          state_reg <= INIT;
        end
        INIT: begin
          s_address <= i_reg;
          s_data    <= i_reg;
          s_wren    <= 1'b1;
          i_reg     <= i_reg + 8'd1;
          if (i_reg == 8'hFF) begin
            j_reg     <= '0;
            state_reg <= K_RD_I;
          end
        end
        K_RD_I: begin
          s_wren    <= 1'b0;
          s_address <= i_reg;
          state_reg <= K_WT_I;
        end
        K_WT_I: state_reg <= K_RD_J;
        K_RD_J: begin
          si_reg    <= s_q;
          j_reg     <= j_ksa;
          s_address <= j_ksa;
          state_reg <= K_WT_J;
        end
        K_WT_J: state_reg <= K_WR_I;
        K_WR_I: begin
          s_address <= i_reg;
          s_data    <= s_q;
          s_wren    <= 1'b1;
          state_reg <= K_WR_J;
        end
        K_WR_J: begin
          s_address <= j_reg;
          s_data    <= si_reg;
          s_wren    <= 1'b1;
          i_reg     <= i_reg + 8'd1;
          key_reg   <= key_rot;
          if (i_reg == 8'hFF) begin
            j_reg     <= '0;
            k_reg     <= '0;
            state_reg <= P_RD_I;
          end else begin
            state_reg <= K_RD_I;
          end
        end
        P_RD_I: begin
          s_wren      <= 1'b0;
          dec_wren    <= 1'b0;
          i_reg       <= i_reg + 8'd1;
          s_address   <= i_reg + 8'd1;
          rom_address <= k_reg[ADDR_W-1:0];
          state_reg   <= P_WT_I;
        end
        P_WT_I: state_reg <= P_RD_J;
        P_RD_J: begin
          si_reg    <= s_q;
          ct_reg    <= rom_q;
          j_reg     <= j_prga;
          s_address <= j_prga;
          state_reg <= P_WT_J;
        end
        P_WT_J: state_reg <= P_WR_I;
        P_WR_I: begin
          sj_reg    <= s_q;
          s_address <= i_reg;
          s_data    <= s_q;
          s_wren    <= 1'b1;
          state_reg <= P_WR_J;
        end
        P_WR_J: begin
          s_address <= j_reg;
          s_data    <= si_reg;
          state_reg <= P_RD_F;
        end
        P_RD_F: begin
          s_wren    <= 1'b0;
          s_address <= si_reg + sj_reg;
          state_reg <= P_WT_F;
        end
        P_WT_F: state_reg <= P_OUT;
        P_OUT: begin
          // An illegal byte is still written so the caller can inspect where the key failed.
          dec_address <= k_reg[ADDR_W-1:0];
          dec_data    <= pt_byte;
          dec_wren    <= 1'b1;
          if (CHECK_PLAINTEXT && !pt_legal) begin
            key_valid <= 1'b0;
            state_reg <= FINISH;
          end else if (k_reg == K_LAST) begin
            key_valid <= 1'b1;
            state_reg <= FINISH;
          end else begin
            k_reg     <= k_reg + 1'b1;
            state_reg <= P_RD_I;
          end
        end
        FINISH: begin
          dec_wren  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Bench for rc4_decrypt_core: three parameterisations with behavioural RAM/ROM models,
// fixed known-answer vectors, randomized keys/messages against an RC4 reference, reset and start-spam cases.
module tb_rc4_decrypt_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start [3];
  logic [23:0] key_a, key_b;
  logic [31:0] key_c;
  logic [7:0]  s_address [3], s_data [3], s_q [3], rom_q [3], dec_data [3];
  logic        s_wren [3], dec_wren [3], busy [3], done [3], key_valid [3];
  logic [4:0]  rom_address [3], dec_address [3];

  logic [7:0]  s_mem   [3][256];
  logic [7:0]  rom_mem [3][32];
  logic [7:0]  dec_mem [3][32];
  int          s_cnt [3], dec_cnt [3], overlap_cnt [3];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_pt [32];
  logic [7:0]  m_key  [32];
  logic [7:0]  m_ks   [256];

  rc4_decrypt_core #(.KEY_LENGTH(3), .MSG_LENGTH(9), .CHECK_PLAINTEXT(1'b0), .ADDR_W(5)) dut_a (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start[0]), .key(key_a),
    .s_address(s_address[0]), .s_data(s_data[0]), .s_wren(s_wren[0]), .s_q(s_q[0]),
    .rom_address(rom_address[0]), .rom_q(rom_q[0]),
    .dec_address(dec_address[0]), .dec_data(dec_data[0]), .dec_wren(dec_wren[0]),
    .busy(busy[0]), .done(done[0]), .key_valid(key_valid[0]));

  rc4_decrypt_core #(.KEY_LENGTH(3), .MSG_LENGTH(9), .CHECK_PLAINTEXT(1'b1), .ADDR_W(5)) dut_b (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start[1]), .key(key_b),
    .s_address(s_address[1]), .s_data(s_data[1]), .s_wren(s_wren[1]), .s_q(s_q[1]),
    .rom_address(rom_address[1]), .rom_q(rom_q[1]),
    .dec_address(dec_address[1]), .dec_data(dec_data[1]), .dec_wren(dec_wren[1]),
    .busy(busy[1]), .done(done[1]), .key_valid(key_valid[1]));

  rc4_decrypt_core #(.KEY_LENGTH(4), .MSG_LENGTH(5), .CHECK_PLAINTEXT(1'b1), .ADDR_W(5)) dut_c (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start[2]), .key(key_c),
    .s_address(s_address[2]), .s_data(s_data[2]), .s_wren(s_wren[2]), .s_q(s_q[2]),
    .rom_address(rom_address[2]), .rom_q(rom_q[2]),
    .dec_address(dec_address[2]), .dec_data(dec_data[2]), .dec_wren(dec_wren[2]),
    .busy(busy[2]), .done(done[2]), .key_valid(key_valid[2]));

  // Synchronous memories with one cycle of read latency, plus write-activity counters.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (s_wren[d]) s_mem[d][s_address[d]] <= s_data[d];
      s_q[d]   <= s_mem[d][s_address[d]];
      rom_q[d] <= rom_mem[d][rom_address[d]];
      if (dec_wren[d]) dec_mem[d][dec_address[d]] <= dec_data[d];
      if (!reset_n) begin
        s_cnt[d]       <= 0;
        dec_cnt[d]     <= 0;
        overlap_cnt[d] <= 0;
      end else begin
        if (s_wren[d])               s_cnt[d]       <= s_cnt[d] + 1;
        if (dec_wren[d])             dec_cnt[d]     <= dec_cnt[d] + 1;
        if (s_wren[d] && dec_wren[d]) overlap_cnt[d] <= overlap_cnt[d] + 1;
      end
    end
  end

  typedef struct {
    int          d;
    logic [31:0] key;
    int          n;
    logic [71:0] ct;
    logic [71:0] pt;
    int          nwr;
    bit          valid;
  } vec_t;

  vec_t vecs [3];

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_word(input int d);
    return {25'd0, s_address[d], s_data[d], s_wren[d], rom_address[d], dec_address[d],
            dec_data[d], dec_wren[d], busy[d], done[d], key_valid[d]};
  endfunction

  function automatic bit is_text(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  task automatic set_key(input int d, input logic [31:0] k);
    case (d)
      0:       key_a = k[23:0];
      1:       key_b = k[23:0];
      default: key_c = k;
    endcase
  endtask

  task automatic set_model_key(input logic [31:0] k, input int klen);
    for (int b = 0; b < klen; b++) m_key[b] = 8'(k >> (8 * (klen - 1 - b)));
  endtask

  // Textbook RC4: identity permutation, key schedule, then n keystream bytes.
  task automatic model_keystream(input int klen, input int n);
    int s [256];
    int i, j, t;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + s[x] + int'(m_key[x % klen])) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int x = 0; x < n; x++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      m_ks[x] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  task automatic load_vec(input int v);
    set_key(vecs[v].d, vecs[v].key);
    for (int b = 0; b < 32; b++) rom_mem[vecs[v].d][b] = 8'h00;
    for (int b = 0; b < vecs[v].n; b++) begin
      rom_mem[vecs[v].d][b] = vecs[v].ct[8*(9-b)-1 -: 8];
      exp_pt[b]             = vecs[v].pt[8*(9-b)-1 -: 8];
    end
  endtask

  task automatic run_dut(input int d, input bit spam, input bit toggle, input bit chk_init,
                         input string tag, input int exp_wr, input bit exp_valid);
    int          cyc, dec0, s0, exp_cyc, bad_init;
    logic [23:0] key_save;
    exp_cyc  = 1 + 256 + 1536 + 9 * exp_wr + 1;
    dec0     = dec_cnt[d];
    s0       = s_cnt[d];
    key_save = key_a;
    @(negedge clk);
    start[d] = 1'b1;
    cyc = 0;
    while ((cyc == 0 || !done[d]) && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        start[d] = 1'b0;
        compare({tag, " start_ack busy/done/valid"}, {61'd0, busy[d], done[d], key_valid[d]}, 64'b100);
      end
      if (spam && cyc > 1) start[d] = (cyc < 1500) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (toggle && d == 0) key_a = 24'($urandom);
      if (chk_init && cyc == 260) begin
        bad_init = 0;
        for (int n = 0; n < 256; n++) if (s_mem[d][n] !== 8'(n)) bad_init++;
        compare({tag, " s_init_nonidentity_entries"}, 64'(bad_init), 64'd0);
      end
    end
    start[d] = 1'b0;
    if (toggle) key_a = key_save;
    compare({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
    compare({tag, " key_valid"}, 64'(key_valid[d]), 64'(exp_valid));
    compare({tag, " busy_at_done"}, 64'(busy[d]), 64'd0);
    compare({tag, " dec_writes"}, 64'(dec_cnt[d] - dec0), 64'(exp_wr));
    compare({tag, " s_writes"}, 64'(s_cnt[d] - s0), 64'(256 + 512 + 2 * exp_wr));
    for (int b = 0; b < exp_wr; b++)
      compare($sformatf("%s dec_byte[%0d]", tag, b), 64'(dec_mem[d][b]), 64'(exp_pt[b]));
    $display("run %s: dut=%0d cycles=%0d key_valid=%0b dec_writes=%0d", tag, d, cyc, key_valid[d],
             dec_cnt[d] - dec0);
  endtask

  initial begin
    logic [31:0] rkey;
    logic [7:0]  ct, pt;
    int          p, wait_cyc;

    vecs[0] = '{d: 0, key: 32'h004B6579, n: 9, ct: 72'hBBF316E8D940AF0AD3,
                pt: 72'h506C61696E74657874, nwr: 9, valid: 1'b1};
    vecs[1] = '{d: 1, key: 32'h004B6579, n: 9, ct: 72'hBBF316E8D940AF0AD3,
                pt: 72'h506C61696E74657874, nwr: 1, valid: 1'b0};
    vecs[2] = '{d: 2, key: 32'h57696B69, n: 5, ct: 72'h1021BF0420_00000000,
                pt: 72'h7065646961_00000000, nwr: 5, valid: 1'b1};

    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) start[d] = 1'b0;
    key_a = '0;
    key_b = '0;
    key_c = '0;
    for (int d = 0; d < 3; d++) for (int b = 0; b < 32; b++) rom_mem[d][b] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) compare($sformatf("reset_outputs dut%0d", d), out_word(d), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 3; v++) begin
      load_vec(v);
      run_dut(vecs[v].d, 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", v), vecs[v].nwr, vecs[v].valid);
    end

    load_vec(0);
    run_dut(0, 1'b1, 1'b0, 1'b1, "start_spam", 9, 1'b1);
    load_vec(0);
    run_dut(0, 1'b0, 1'b1, 1'b0, "key_toggle", 9, 1'b1);

    for (int r = 0; r < 3; r++) begin
      rkey = {8'h00, 24'($urandom)};
      set_key(0, rkey);
      set_model_key(rkey, 3);
      model_keystream(3, 9);
      for (int b = 0; b < 9; b++) begin
        ct = 8'($urandom);
        rom_mem[0][b] = ct;
        exp_pt[b] = ct ^ m_ks[b];
      end
      run_dut(0, 1'b0, 1'b0, 1'b0, $sformatf("rand_nocheck%0d", r), 9, 1'b1);
    end

    for (int r = 0; r < 3; r++) begin
      rkey = $urandom;
      set_key(2, rkey);
      set_model_key(rkey, 4);
      model_keystream(4, 5);
      p = $urandom_range(0, 5);
      for (int b = 0; b < 5; b++) begin
        if (b < p) begin
          wait_cyc = $urandom_range(0, 26);
          pt = (wait_cyc == 26) ? 8'h20 : 8'(8'h61 + wait_cyc);
        end else if (b == p) begin
          do pt = 8'($urandom); while (is_text(pt));
        end else begin
          pt = 8'($urandom);
        end
        rom_mem[2][b] = pt ^ m_ks[b];
        exp_pt[b] = pt;
      end
      run_dut(2, 1'b0, 1'b0, 1'b0, $sformatf("rand_check%0d_abort_at_%0d", r, p),
              (p < 5) ? p + 1 : 5, p == 5);
    end

    for (int d = 0; d < 3; d++)
      compare($sformatf("wren_overlap dut%0d", d), 64'(overlap_cnt[d]), 64'd0);

    load_vec(0);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_cyc = $urandom_range(300, 1700);
    repeat (wait_cyc) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    compare("async_reset_outputs", out_word(0), 64'd0);
    $display("mid-run reset applied %0d cycles into the run", wait_cyc);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_dut(0, 1'b0, 1'b0, 1'b0, "after_reset", 9, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rc4_decrypt_core.md
Name: rc4_decrypt_core

Overview:
Parametrised successor to the fixed-key S-init/shuffle datapath. One start pulse runs the full RC4 flow on external single-port RAM/ROM: S init, KSA shuffle with a latched key of KEY_LENGTH bytes, then PRGA decryption of MSG_LENGTH ciphertext bytes into the decrypted RAM. An optional plaintext checker aborts early on an illegal byte, so the core can be used directly by a key-search controller.

Parameters:
KEY_LENGTH, 3, key bytes (1..32); key byte 0 = key[8*KEY_LENGTH-1 -: 8].
MSG_LENGTH, 32, ciphertext/plaintext bytes (1..256).
CHECK_PLAINTEXT, 1, 1 = abort on a byte outside {0x61..0x7A, 0x20}; 0 = never abort.
ADDR_W, 5, ROM/decrypted RAM address width; must satisfy 2**ADDR_W >= MSG_LENGTH.

Ports:
CLOCK_50  in  1  sole clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
key  in  8*KEY_LENGTH  secret key; latched on the accepted start.
s_address  out  8  S RAM address.
s_data  out  8  S RAM write data.
s_wren  out  1  S RAM write enable.
s_q  in  8  S RAM read data; valid 1 cycle after the address is presented.
rom_address  out  ADDR_W  ciphertext ROM address.
rom_q  in  8  ROM data; 1-cycle latency.
dec_address  out  ADDR_W  decrypted RAM address.
dec_data  out  8  plaintext byte.
dec_wren  out  1  decrypted RAM write enable.
busy  out  1  high from the cycle after start until done.
done  out  1  level; high from run end until the next accepted start.
key_valid  out  1  meaningful when done=1: 1 = all bytes legal (or check disabled).

Behaviour:
- Reset (async, any state): state=IDLE; all address/data/wren outputs = 0; busy = done = key_valid = 0; i = j = k = 0.
- IDLE: start=1 -> latch key, clear done/key_valid, busy=1, go to INIT. Start while busy is ignored.
- INIT: i = 0..255, write S[i]=i, one write per cycle (256 cycles). Then i=j=0 -> KSA.
- KSA: 6 cycles per i.
  - K_RD_I: s_address=i.
  - K_WT_I: wait for read data.
  - K_RD_J: si=s_q; j=j+si+key_byte[i mod KEY_LENGTH] (8-bit wrap); s_address=new j.
  - K_WT_J: wait for read data.
  - K_WR_I: sj=s_q; write S[i]=sj.
  - K_WR_J: write S[j]=si; i++.
  - i wraps 255 -> 0: go to PRGA with i=j=k=0. Total 1536 cycles.
- PRGA: 9 cycles per k.
  - P_RD_I: i=i+1; s_address=i; rom_address=k.
  - P_WT_I: wait for read data.
  - P_RD_J: si=s_q; ct=rom_q; j=j+si; s_address=j.
  - P_WT_J: wait for read data.
  - P_WR_I: sj=s_q; write S[i]=sj.
  - P_WR_J: write S[j]=si.
  - P_RD_F: s_address=si+sj (8-bit wrap).
  - P_WT_F: wait for read data.
  - P_OUT: dec_address=k; dec_data=s_q^ct; dec_wren=1.
- Checker: in P_OUT, if CHECK_PLAINTEXT=1 and the byte is illegal, the byte is still written, then go to FINISH with key_valid=0. Otherwise k++; k==MSG_LENGTH-1 -> FINISH with key_valid=1.
- FINISH (1 cycle): busy=0, done=1, all wren=0, then IDLE.
- Latency: done rises exactly 1+256+1536+9*MSG_LENGTH+1 cycles after the start edge (full run). An abort at byte k rises after 1+256+1536+9*(k+1)+1 cycles.
- Write enables are high only in their write states, never otherwise. s_wren and dec_wren are never high in the same cycle.
- Key changing during a run has no effect. reset_n low mid-run discards the run; memory contents are don't-care.

Test Plan:
- KEY_LENGTH=3, key=0x4B6579 ("Key"), MSG_LENGTH=9, CHECK_PLAINTEXT=0, ROM=BB F3 16 E8 D9 40 AF 0A D3 -> dec RAM = "Plaintext" (50 6C 61 69 6E 74 65 78 74); key_valid=1; done at cycle 1+256+1536+81+1.
- Same ROM, CHECK_PLAINTEXT=1 -> exactly one dec write (addr 0, 0x50); done, key_valid=0 after 1+256+1536+9+1 cycles.
- KEY_LENGTH=4, key="Wiki" (0x57696B69), MSG_LENGTH=5, CHECK_PLAINTEXT=1, ROM=10 21 BF 04 20 -> "pedia" (70 65 64 69 61); key_valid=1.
- After INIT, before KSA: S RAM model holds S[n]=n for all 256 entries. Start pulses during busy are ignored: exactly one run, identical outputs.
- reset_n low at a random KSA cycle -> all outputs 0 immediately (asynchronous). After release, a new start on vector 1 reproduces the exact result.
- Key port toggled every cycle during a run -> result equals that for the key latched at start.
